emif_calbus_router_nch: RTL and testbench

Parametrised N-channel calibration-bus router between one soft calibration master (CSR bridge or sequencer) and NUM_CH EMIF calbus channel ports. It accepts one request at a time and issues single-cycle calbus read/write strobes to the selected channel. It also supports broadcast writes to all channels and direct word reads from each channel's sequencer parameter table. Every accepted request returns exactly one response.

---
 rtl/emif_calbus_router_nch.sv | 204 ++++++++++++++++++++
 tb/tb_emif_calbus_router_nch.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emif_calbus_router_nch.sv
// N-channel calibration-bus router: one soft master, NUM_CH calbus ports.
// Serves one request at a time with unicast/broadcast writes, reads and parameter-table reads.
module emif_calbus_router_nch #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TBL_W  = 4096,
  parameter int unsigned RD_LAT = 2,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned TBL_WORDS = TBL_W / DATA_W,
  localparam int unsigned TBL_IDX_W = (TBL_WORDS > 1) ? $clog2(TBL_WORDS) : 1
) (
  input  logic                       calbus_clk,
  input  logic                       calbus_rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic                       req_bcast,
  input  logic                       req_tbl,
  input  logic [CH_W-1:0]            req_ch,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       rsp_valid,
  output logic                       rsp_err,
  output logic [CH_W-1:0]            rsp_ch,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic [NUM_CH-1:0]          calbus_read,
  output logic [NUM_CH-1:0]          calbus_write,
  output logic [NUM_CH*ADDR_W-1:0]   calbus_address,
  output logic [NUM_CH*DATA_W-1:0]   calbus_wdata,
  input  logic [NUM_CH*DATA_W-1:0]   calbus_rdata,
  input  logic [NUM_CH*TBL_W-1:0]    calbus_seq_param_tbl
);

  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CH_W-1:0] LastCh = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {StIdle, StWr, StRdStb, StRdWait, StRsp} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;      // active channel, doubles as broadcast counter
  logic                bcast_q, bcast_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [LAT_W-1:0]    lat_q, lat_d;

  logic                      ready_d;
  logic                      rsp_err_d;
  logic [CH_W-1:0]           rsp_ch_d;
  logic [DATA_W-1:0]         rsp_rdata_d;
  logic [NUM_CH-1:0]         read_d, write_d;
  logic [NUM_CH*ADDR_W-1:0]  address_d;
  logic [NUM_CH*DATA_W-1:0]  wdata_bus_d;

  logic                  accept;
  logic                  req_err;
  logic [TBL_IDX_W-1:0]  tbl_idx;
  logic [TBL_W-1:0]      chan_tbl;
  logic [DATA_W-1:0]     tbl_word;
  logic [DATA_W-1:0]     rd_word;

  assign accept  = req_valid & req_ready;
  assign req_err = req_bcast ? ~req_write : (32'(req_ch) >= NUM_CH);
  assign tbl_idx = (TBL_WORDS > 1) ? req_addr[TBL_IDX_W-1:0] : '0;

  // Table word lookup for the requested channel, straight from the input.
  always_comb begin
    chan_tbl = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req_ch == CH_W'(i)) chan_tbl = calbus_seq_param_tbl[i*TBL_W +: TBL_W];
    end
    tbl_word = '0;
    for (int w = 0; w < TBL_WORDS; w++) begin
      if (tbl_idx == TBL_IDX_W'(w)) tbl_word = chan_tbl[w*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == CH_W'(i)) rd_word = calbus_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    bcast_d     = bcast_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    rsp_err_d   = 1'b0;
    rsp_ch_d    = '0;
    rsp_rdata_d = '0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          ch_d    = req_ch;
          bcast_d = 1'b0;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          lat_d   = '0;
          if (req_err) begin
            state_d   = StRsp;
            rsp_err_d = 1'b1;
            rsp_ch_d  = req_ch;
          end else if (req_tbl) begin
            state_d     = StRsp;
            rsp_ch_d    = req_ch;
            rsp_rdata_d = tbl_word;
          end else if (req_write) begin
            state_d = StWr;
            if (req_bcast) begin
              bcast_d = 1'b1;
              ch_d    = '0;
            end
          end else begin
            state_d = StRdStb;
          end
        end
      end
      StWr: begin
        if (bcast_q && (ch_q != LastCh)) begin
          ch_d = ch_q + CH_W'(1);
        end else begin
          state_d  = StRsp;
          rsp_ch_d = ch_q;
        end
      end
      StRdStb: begin
        state_d = StRdWait;
        lat_d   = '0;
      end
      StRdWait: begin
        if (lat_q == LAT_W'(RD_LAT - 1)) begin
          state_d     = StRsp;
          rsp_ch_d    = ch_q;
          rsp_rdata_d = rd_word;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      StRsp:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus outputs are derived from the next state so they land in the same cycle as the state.
  always_comb begin
    ready_d     = (state_d == StIdle);
    read_d      = '0;
    write_d     = '0;
    address_d   = '0;
    wdata_bus_d = '0;
    if (state_d inside {StWr, StRdStb, StRdWait}) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_d == CH_W'(i)) begin
          address_d[i*ADDR_W +: ADDR_W]   = addr_d;
          wdata_bus_d[i*DATA_W +: DATA_W] = wdata_d;
          write_d[i] = (state_d == StWr);
          read_d[i]  = (state_d == StRdStb);
        end
      end
    end
  end

  always_ff @(posedge calbus_clk) begin
    if (calbus_rst) begin
      state_q        <= StIdle;
      ch_q           <= '0;
      bcast_q        <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      lat_q          <= '0;
      req_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_ch         <= '0;
      rsp_rdata      <= '0;
      calbus_read    <= '0;
      calbus_write   <= '0;
      calbus_address <= '0;
      calbus_wdata   <= '0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      bcast_q        <= bcast_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      lat_q          <= lat_d;
      req_ready      <= ready_d;
      rsp_valid      <= (state_d == StRsp);
      rsp_err        <= rsp_err_d;
      rsp_ch         <= rsp_ch_d;
      rsp_rdata      <= rsp_rdata_d;
      calbus_read    <= read_d;
      calbus_write   <= write_d;
      calbus_address <= address_d;
      calbus_wdata   <= wdata_bus_d;
    end
  end

endmodule

// File: tb/tb_emif_calbus_router_nch.sv
// Self-checking bench for emif_calbus_router_nch: directed scenarios plus randomized
// requests checked cycle by cycle against a transaction-level expectation model.
module tb_emif_calbus_router_nch;

  localparam int NUM_CH    = 4;
  localparam int ADDR_W    = 20;
  localparam int DATA_W    = 32;
  localparam int TBL_W     = 4096;
  localparam int RD_LAT    = 2;
  localparam int CH_W      = 2;
  localparam int TBL_WORDS = TBL_W / DATA_W;
  localparam int OBS_W     = 3 + CH_W + DATA_W + 2*NUM_CH + NUM_CH*(ADDR_W + DATA_W);

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      req_valid = 1'b0, req_ready;
  logic                      req_write = 1'b0, req_bcast = 1'b0, req_tbl = 1'b0;
  logic [CH_W-1:0]           req_ch = '0;
  logic [ADDR_W-1:0]         req_addr = '0;
  logic [DATA_W-1:0]         req_wdata = '0;
  logic                      rsp_valid, rsp_err;
  logic [CH_W-1:0]           rsp_ch;
  logic [DATA_W-1:0]         rsp_rdata;
  logic [NUM_CH-1:0]         calbus_read, calbus_write;
  logic [NUM_CH*ADDR_W-1:0]  calbus_address;
  logic [NUM_CH*DATA_W-1:0]  calbus_wdata;
  logic [NUM_CH*DATA_W-1:0]  calbus_rdata = '0;
  logic [NUM_CH*TBL_W-1:0]   calbus_seq_param_tbl = '0;

  logic [DATA_W-1:0] tbl_model [NUM_CH][TBL_WORDS];
  logic [OBS_W-1:0]  obs;
  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    bit                write, bcast, tbl;
    logic [CH_W-1:0]   ch;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  assign obs = {req_ready, rsp_valid, rsp_err, rsp_ch, rsp_rdata, calbus_read, calbus_write,
                calbus_address, calbus_wdata};

  emif_calbus_router_nch #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TBL_W  (TBL_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .calbus_clk           (clk),
    .calbus_rst           (rst),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_write            (req_write),
    .req_bcast            (req_bcast),
    .req_tbl              (req_tbl),
    .req_ch               (req_ch),
    .req_addr             (req_addr),
    .req_wdata            (req_wdata),
    .rsp_valid            (rsp_valid),
    .rsp_err              (rsp_err),
    .rsp_ch               (rsp_ch),
    .rsp_rdata            (rsp_rdata),
    .calbus_read          (calbus_read),
    .calbus_write         (calbus_write),
    .calbus_address       (calbus_address),
    .calbus_wdata         (calbus_wdata),
    .calbus_rdata         (calbus_rdata),
    .calbus_seq_param_tbl (calbus_seq_param_tbl)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running (got timeout want finish)");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic bit is_err(req_t r);
    return r.bcast ? !r.write : (int'(r.ch) >= NUM_CH);
  endfunction

  function automatic int rsp_offset(req_t r);
    if (is_err(r) || r.tbl) return 1;
    if (r.write) return r.bcast ? NUM_CH + 1 : 2;
    return RD_LAT + 2;
  endfunction

  // Expected outputs k cycles after acceptance.
  function automatic logic [OBS_W-1:0] expect_out(req_t r, int k, logic [DATA_W-1:0] rd_val);
    int off = rsp_offset(r);
    int act;
    logic rdy = 1'b0, rv = 1'b0, re = 1'b0;
    logic [CH_W-1:0] cho = '0;
    logic [DATA_W-1:0] rdat = '0;
    logic [NUM_CH-1:0] rd = '0, wr = '0;
    logic [NUM_CH*ADDR_W-1:0] ad = '0;
    logic [NUM_CH*DATA_W-1:0] wd = '0;
    if (k == off) begin
      rv = 1'b1;
      re = is_err(r);
      cho = (r.bcast && r.write && !r.tbl) ? CH_W'(NUM_CH - 1) : r.ch;
      if (!re && r.tbl) rdat = tbl_model[r.ch][int'(r.addr) % TBL_WORDS];
      else if (!re && !r.write) rdat = rd_val;
    end else if (k > off) begin
      rdy = 1'b1;
    end else begin
      act = r.bcast ? k - 1 : int'(r.ch);
      ad[act*ADDR_W +: ADDR_W] = r.addr;
      wd[act*DATA_W +: DATA_W] = r.wdata;
      if (r.write) begin
        if (r.bcast || k == 1) wr[act] = 1'b1;
      end else if (k == 1) begin
        rd[act] = 1'b1;
      end
    end
    return {rdy, rv, re, cho, rdat, rd, wr, ad, wd};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic fill_tables();
    for (int c = 0; c < NUM_CH; c++)
      for (int w = 0; w < TBL_WORDS; w++) begin
        tbl_model[c][w] = $urandom;
        calbus_seq_param_tbl[c*TBL_W + w*DATA_W +: DATA_W] = tbl_model[c][w];
      end
  endtask

  // Presents a request and returns one cycle after acceptance, fields scrambled.
  task automatic start_req(input req_t r, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    req_write = r.write; req_bcast = r.bcast; req_tbl = r.tbl;
    req_ch = r.ch; req_addr = r.addr; req_wdata = r.wdata;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_bcast = 1'($urandom); req_tbl = 1'($urandom);
    req_ch = CH_W'($urandom); req_addr = ADDR_W'($urandom); req_wdata = $urandom;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", obs);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs !== {1'b1, {(OBS_W-1){1'b0}}}) begin
      n_fail++; $display("FAIL reset_release_ready: got %h want ready only", obs);
    end
  endtask

  task automatic test_unicast_write();
    req_t r = '{write: 1, bcast: 0, tbl: 0, ch: 2, addr: 20'h00ABC, wdata: 32'hDEADBEEF};
    bit ok;
    logic [NUM_CH*ADDR_W-1:0] ea = '0;
    ea[2*ADDR_W +: ADDR_W] = 20'h00ABC;
    start_req(r, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL wr_accept: got no ready want ready"); end
    @(negedge clk);
    n_cmp++;
    if ({calbus_write, calbus_read, rsp_valid, req_ready} !== {4'b0100, 4'b0000, 2'b00}) begin
      n_fail++; $display("FAIL wr_strobe: got w=%b r=%b v=%b", calbus_write, calbus_read, rsp_valid);
    end
    n_cmp++;
    if (calbus_address !== ea || calbus_wdata[2*DATA_W +: DATA_W] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wr_bus: got a=%h d=%h want a=%h", calbus_address, calbus_wdata, ea);
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_ch, rsp_rdata, calbus_write} !== {1'b1, 1'b0, 2'd2, 32'd0, 4'd0})
    begin
      n_fail++;
      $display("FAIL wr_rsp: got v=%b e=%b ch=%0d d=%h w=%b want 1 0 2 0 0",
               rsp_valid, rsp_err, rsp_ch, rsp_rdata, calbus_write);
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL wr_idle: got v=%b rdy=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_read();
    req_t r = '{write: 0, bcast: 0, tbl: 0, ch: 1, addr: 20'h12345, wdata: 32'h0};
    bit ok;
    start_req(r, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL rd_accept: got no ready want ready"); end
    calbus_rdata = {NUM_CH{32'h11111111}};
    @(negedge clk);
    n_cmp++;
    if ({calbus_read, calbus_write} !== {4'b0010, 4'b0000}
        || calbus_address[ADDR_W +: ADDR_W] !== 20'h12345) begin
      n_fail++; $display("FAIL rd_strobe: got r=%b w=%b a=%h", calbus_read, calbus_write,
                         calbus_address);
    end
    @(posedge clk); #1;
    @(posedge clk); #1 calbus_rdata[DATA_W +: DATA_W] = 32'hCAFEF00D;
    @(posedge clk); #1 calbus_rdata = {NUM_CH{32'h22222222}};
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_ch, rsp_rdata} !== {1'b1, 1'b0, 2'd1, 32'hCAFEF00D}) begin
      n_fail++; $display("FAIL rd_rsp: got v=%b e=%b ch=%0d d=%h want 1 0 1 cafef00d",
                         rsp_valid, rsp_err, rsp_ch, rsp_rdata);
    end
  endtask

  task automatic test_bcast();
    req_t r = '{write: 1, bcast: 1, tbl: 0, ch: 2, addr: 20'h00777, wdata: 32'h5A5A5A5A};
    bit ok;
    logic [NUM_CH-1:0] ew;
    start_req(r, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL bc_accept: got no ready want ready"); end
    for (int k = 1; k <= NUM_CH; k++) begin
      @(negedge clk);
      ew = '0;
      ew[k-1] = 1'b1;
      n_cmp++;
      if ({calbus_write, req_ready, rsp_valid} !== {ew, 2'b00}
          || calbus_wdata[(k-1)*DATA_W +: DATA_W] !== 32'h5A5A5A5A) begin
        n_fail++; $display("FAIL bc_strobe%0d: got w=%b rdy=%b d=%h want w=%b", k, calbus_write,
                           req_ready, calbus_wdata, ew);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_ch, req_ready, calbus_write} !== {1'b1, 1'b0, 2'd3, 1'b0, 4'd0})
    begin
      n_fail++; $display("FAIL bc_rsp: got v=%b e=%b ch=%0d rdy=%b w=%b want 1 0 3 0 0",
                         rsp_valid, rsp_err, rsp_ch, req_ready, calbus_write);
    end
  endtask

  task automatic test_table_err();
    req_t r = '{write: 0, bcast: 0, tbl: 1, ch: 3, addr: 20'h0007F, wdata: 32'h0};
    bit ok;
    tbl_model[3][127] = 32'h01020304;
    calbus_seq_param_tbl[3*TBL_W + 127*DATA_W +: DATA_W] = 32'h01020304;
    start_req(r, ok);
    @(negedge clk);
    n_cmp++;
    if (!ok || {rsp_valid, rsp_err, rsp_ch, rsp_rdata, calbus_read, calbus_write}
        !== {1'b1, 1'b0, 2'd3, 32'h01020304, 8'd0}) begin
      n_fail++; $display("FAIL tbl_rsp: got v=%b e=%b ch=%0d d=%h r=%b w=%b want 1 0 3 01020304",
                         rsp_valid, rsp_err, rsp_ch, rsp_rdata, calbus_read, calbus_write);
    end
    r = '{write: 0, bcast: 1, tbl: 0, ch: 2, addr: 20'h00100, wdata: 32'h0};
    start_req(r, ok);
    @(negedge clk);
    n_cmp++;
    if (!ok || {rsp_valid, rsp_err, rsp_ch, rsp_rdata, calbus_read, calbus_write}
        !== {1'b1, 1'b1, 2'd2, 32'd0, 8'd0}) begin
      n_fail++; $display("FAIL bcrd_err: got v=%b e=%b ch=%0d d=%h r=%b w=%b want 1 1 2 0",
                         rsp_valid, rsp_err, rsp_ch, rsp_rdata, calbus_read, calbus_write);
    end
  endtask

  task automatic test_reset_mid();
    req_t r = '{write: 0, bcast: 0, tbl: 0, ch: 0, addr: 20'h00042, wdata: 32'h0};
    bit ok;
    int stray = 0;
    start_req(r, ok);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs !== '0) begin n_fail++; $display("FAIL rstmid_zero: got %h want 0", obs); end
    @(negedge clk);
    n_cmp++;
    if (obs !== {1'b1, {(OBS_W-1){1'b0}}}) begin
      n_fail++; $display("FAIL rstmid_ready: got %h want ready only", obs);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) stray++;
    end
    n_cmp++;
    if (stray !== 0) begin n_fail++; $display("FAIL rstmid_stray: got %0d want 0", stray); end
    r = '{write: 1, bcast: 0, tbl: 0, ch: 3, addr: 20'h00055, wdata: 32'h600DF00D};
    start_req(r, ok);
    @(negedge clk);
    n_cmp++;
    if (!ok || calbus_write !== 4'b1000) begin
      n_fail++; $display("FAIL rstmid_wr: got w=%b want 1000", calbus_write);
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_ch} !== {1'b1, 1'b0, 2'd3}) begin
      n_fail++; $display("FAIL rstmid_rsp: got v=%b e=%b ch=%0d want 1 0 3", rsp_valid, rsp_err,
                         rsp_ch);
    end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int pulses = 0;
    @(posedge clk); #1;
    req_write = 1'b1; req_bcast = 1'b0; req_tbl = 1'b0; req_ch = 2'd1;
    req_addr = 20'h00300; req_wdata = 32'h12345678; req_valid = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (req_valid && req_ready) acc.push_back(cyc);
      if (rsp_valid) pulses++;
      @(posedge clk); #1;
      if (acc.size() == 3) req_valid = 1'b0;
    end
    n_cmp++;
    if (acc.size() != 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d acceptances want 3", acc.size());
    end else if (acc[1] - acc[0] != 3 || acc[2] - acc[0] != 6) begin
      n_fail++; $display("FAIL b2b_spacing: got +%0d +%0d want +3 +6", acc[1] - acc[0],
                         acc[2] - acc[0]);
    end
    n_cmp++;
    if (pulses != 3) begin n_fail++; $display("FAIL b2b_rsp: got %0d want 3", pulses); end
  endtask

  task automatic test_random();
    req_t r;
    bit ok;
    int off;
    logic [DATA_W-1:0] rd_val;
    logic [OBS_W-1:0] exp_o;
    for (int n = 0; n < 60; n++) begin
      r.write = 1'($urandom);
      r.bcast = ($urandom_range(0, 3) == 0);
      r.tbl   = ($urandom_range(0, 3) == 0);
      r.ch    = CH_W'($urandom);
      r.addr  = ADDR_W'($urandom);
      r.wdata = $urandom;
      off = rsp_offset(r);
      rd_val = '0;
      start_req(r, ok);
      n_cmp++;
      if (!ok) begin n_fail++; $display("FAIL rnd_accept%0d: got no ready want ready", n); end
      for (int k = 1; k <= off + 1; k++) begin
        for (int c = 0; c < NUM_CH; c++) calbus_rdata[c*DATA_W +: DATA_W] = $urandom;
        if (k == 1 + RD_LAT) rd_val = calbus_rdata[int'(r.ch)*DATA_W +: DATA_W];
        @(negedge clk);
        exp_o = expect_out(r, k, rd_val);
        n_cmp++;
        if (obs !== exp_o) begin
          n_fail++; $display("FAIL rnd%0d_k%0d: got %h want %h", n, k, obs, exp_o);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    fill_tables();
    test_reset();
    test_unicast_write();
    test_read();
    test_bcast();
    test_table_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
